// File: rtl/washing_machine_pkg.sv
// State codes shared by the washing-machine controller, its interface and the bench.
// No logic; types and constants only.
// No flow control.
package washing_machine_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE    = 3'd0,
        ST_FILL    = 3'd1,
        ST_HEAT    = 3'd2,
        ST_AGITATE = 3'd3,
        ST_DRAIN   = 3'd4,
        ST_SPIN    = 3'd5,
        ST_DONE    = 3'd6
    } state_t;

endpackage

// File: rtl/washing_machine_ctrl_if.sv
// Panel, sensor and actuator pins of the washing-machine controller.
// Master is the machine/panel side, slave is the controller.
// No flow control; level signals sampled every clock.
interface washing_machine_ctrl_if #(
    parameter int CNT_W = 8,
    parameter int R_W   = 2
);
    import washing_machine_pkg::*;

    logic               start;
    logic               abort;
    logic [R_W-1:0]     n_rinses;
    logic               full;
    logic               cold;
    logic               empty;
    logic               ready;
    logic               water_in;
    logic               heat_r;
    logic               wash;
    logic               drain;
    logic               speed;
    logic               done;
    logic [STATE_W-1:0] state_o;
    logic [CNT_W-1:0]   timer_o;

    modport master (
        output start, abort, n_rinses, full, cold, empty,
        input  ready, water_in, heat_r, wash, drain, speed, done, state_o, timer_o
    );

    modport slave (
        input  start, abort, n_rinses, full, cold, empty,
        output ready, water_in, heat_r, wash, drain, speed, done, state_o, timer_o
    );

endinterface

// File: rtl/washing_machine_ctrl_phase_timer.sv
// Down counter timing the AGITATE and SPIN phases; expired while the count is zero.
// Load/clear take effect on the next clock; counts down one per cycle, holds at zero.
// No flow control.
module phase_timer #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] value,
    input  logic             clear,
    output logic [CNT_W-1:0] count,
    output logic             expired
);

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (load) begin
            count <= value;
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign expired = (count == '0);

endmodule

// File: rtl/washing_machine_ctrl.sv
// Washing-machine sequencer: fill, optional heat, timed wash, drain, rinse passes, timed spin, done.
// Outputs are a Moore decode of registered state; every input acts on the next clock.
// No flow control; abort forces a drain and a return to IDLE without a done pulse.
module washing_machine_ctrl
    import washing_machine_pkg::*;
#(
    parameter int CNT_W        = 8,
    parameter int WASH_CYCLES  = 40,
    parameter int RINSE_CYCLES = 20,
    parameter int SPIN_CYCLES  = 20,
    parameter int R_W          = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    washing_machine_ctrl_if.slave bus
);

    localparam int MAX_LEN = (1 << CNT_W) - 1;

    if (WASH_CYCLES < 1 || WASH_CYCLES > MAX_LEN ||
        RINSE_CYCLES < 1 || RINSE_CYCLES > MAX_LEN ||
        SPIN_CYCLES < 1 || SPIN_CYCLES > MAX_LEN) begin : g_bad_len
        $error("washing_machine_ctrl: phase lengths must be in 1..2^CNT_W-1");
    end

    // Loaded values are length-1 so a phase lasts exactly its length including the zero cycle.
    localparam logic [CNT_W-1:0] WASH_LOAD  = CNT_W'(WASH_CYCLES - 1);
    localparam logic [CNT_W-1:0] RINSE_LOAD = CNT_W'(RINSE_CYCLES - 1);
    localparam logic [CNT_W-1:0] SPIN_LOAD  = CNT_W'(SPIN_CYCLES - 1);

    state_t           state, state_nxt;
    logic [R_W-1:0]   n_lat;
    logic [R_W-1:0]   rinse_cnt;
    logic             rinse_flag;
    logic             abort_flag;

    logic             tmr_load;
    logic             tmr_clear;
    logic [CNT_W-1:0] tmr_value;
    logic [CNT_W-1:0] tmr_count;
    logic             tmr_expired;

    phase_timer #(.CNT_W(CNT_W)) u_timer (
        .clk     (clk),
        .reset   (reset),
        .load    (tmr_load),
        .value   (tmr_value),
        .clear   (tmr_clear),
        .count   (tmr_count),
        .expired (tmr_expired)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        tmr_load  = 1'b0;
        tmr_clear = 1'b0;
        tmr_value = '0;
        case (state)
            ST_IDLE: begin
                if (bus.start) state_nxt = ST_FILL;
            end
            ST_FILL: begin
                if (bus.abort) begin
                    state_nxt = ST_DRAIN;
                    tmr_clear = 1'b1;
                end else if (bus.full) begin
                    if (!rinse_flag && bus.cold) begin
                        state_nxt = ST_HEAT;
                    end else begin
                        state_nxt = ST_AGITATE;
                        tmr_load  = 1'b1;
                        tmr_value = rinse_flag ? RINSE_LOAD : WASH_LOAD;
                    end
                end
            end
            ST_HEAT: begin
                // Heating only ever happens on the wash pass.
                if (bus.abort) begin
                    state_nxt = ST_DRAIN;
                    tmr_clear = 1'b1;
                end else if (!bus.cold) begin
                    state_nxt = ST_AGITATE;
                    tmr_load  = 1'b1;
                    tmr_value = WASH_LOAD;
                end
            end
            ST_AGITATE: begin
                if (bus.abort) begin
                    state_nxt = ST_DRAIN;
                    tmr_clear = 1'b1;
                end else if (tmr_expired) begin
                    state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (bus.empty) begin
                    if (abort_flag || bus.abort) begin
                        state_nxt = ST_IDLE;
                    end else if (rinse_cnt < n_lat) begin
                        state_nxt = ST_FILL;
                    end else begin
                        state_nxt = ST_SPIN;
                        tmr_load  = 1'b1;
                        tmr_value = SPIN_LOAD;
                    end
                end
            end
            ST_SPIN: begin
                if (bus.abort) begin
                    state_nxt = ST_DRAIN;
                    tmr_clear = 1'b1;
                end else if (tmr_expired) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Program context: rinse bookkeeping and the pending-abort flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            n_lat      <= '0;
            rinse_cnt  <= '0;
            rinse_flag <= 1'b0;
            abort_flag <= 1'b0;
        end else begin
            if (state == ST_IDLE && bus.start) begin
                n_lat      <= bus.n_rinses;
                rinse_cnt  <= '0;
                rinse_flag <= 1'b0;
                abort_flag <= 1'b0;
            end
            if (bus.abort && state != ST_IDLE && state != ST_DONE) begin
                abort_flag <= 1'b1;
            end
            if (state == ST_DRAIN && state_nxt == ST_FILL) begin
                rinse_flag <= 1'b1;
                rinse_cnt  <= rinse_cnt + 1'b1;
            end
            if (state == ST_DRAIN && state_nxt == ST_IDLE) begin
                abort_flag <= 1'b0;
            end
        end
    end

    always_comb begin
        bus.ready    = (state == ST_IDLE);
        bus.water_in = (state == ST_FILL);
        bus.heat_r   = (state == ST_HEAT);
        bus.wash     = (state == ST_AGITATE);
        bus.drain    = (state == ST_DRAIN);
        bus.speed    = (state == ST_SPIN);
        bus.done     = (state == ST_DONE);
        bus.state_o  = state;
        bus.timer_o  = (state == ST_AGITATE || state == ST_SPIN) ? tmr_count : '0;
    end

endmodule

// File: tb/tb_washing_machine_ctrl.sv
// Directed bench for washing_machine_ctrl: program sequences, heat, rinses, abort, reset.
module tb_washing_machine_ctrl;

    logic clk = 1'b0;
    logic reset;

    washing_machine_ctrl_if #(.CNT_W(8), .R_W(2)) bus ();

    washing_machine_ctrl #(
        .CNT_W(8), .WASH_CYCLES(40), .RINSE_CYCLES(20), .SPIN_CYCLES(20), .R_W(2)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Per-output activity counters, sampled on the falling edge.
    int heat_cnt = 0;
    int done_cnt = 0;
    int drain_entries = 0;
    logic [2:0] prev_st = 3'd0;

    always @(negedge clk) begin
        if (bus.heat_r) heat_cnt++;
        if (bus.done) done_cnt++;
        if (bus.state_o == 3'd4 && prev_st != 3'd4) drain_entries++;
        prev_st <= bus.state_o;
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic measure(input logic [2:0] st, output int n);
        n = 0;
        while (bus.state_o == st && n < 1000) begin
            n++;
            cyc();
        end
    endtask

    int n;
    int k;
    int heat_base, done_base, drain_base;

    initial begin
        reset = 1'b1;
        bus.start = 1'b0; bus.abort = 1'b0; bus.n_rinses = 2'd0;
        bus.full = 1'b0; bus.cold = 1'b0; bus.empty = 1'b0;
        cyc(); cyc();
        chk("rst_state", int'(bus.state_o), 0);
        chk("rst_ready", int'(bus.ready), 1);
        chk("rst_timer", int'(bus.timer_o), 0);
        chk("rst_outs", int'({bus.water_in, bus.heat_r, bus.wash, bus.drain, bus.speed, bus.done}), 0);
        reset = 1'b0;
        cyc();
        chk("idle_hold", int'(bus.state_o), 0);

        // Basic program: no rinse, FILL 3 cycles, DRAIN 2 cycles.
        done_base = done_cnt;
        bus.start = 1'b1; cyc(); bus.start = 1'b0;
        chk("t1_fill", int'(bus.state_o), 1);
        chk("t1_water", int'(bus.water_in), 1);
        cyc(); cyc();
        chk("t1_fill3", int'(bus.state_o), 1);
        bus.full = 1'b1; cyc(); bus.full = 1'b0;
        chk("t1_agit", int'(bus.state_o), 3);
        chk("t1_timer0", int'(bus.timer_o), 39);
        measure(3'd3, n);
        chk("t1_wash_len", n, 40);
        chk("t1_drain", int'(bus.state_o), 4);
        cyc();
        chk("t1_drain2", int'(bus.state_o), 4);
        bus.empty = 1'b1; cyc(); bus.empty = 1'b0;
        chk("t1_spin", int'(bus.state_o), 5);
        chk("t1_spin_timer", int'(bus.timer_o), 19);
        measure(3'd5, n);
        chk("t1_spin_len", n, 20);
        chk("t1_done", int'(bus.state_o), 6);
        chk("t1_done_o", int'(bus.done), 1);
        cyc();
        chk("t1_idle", int'(bus.state_o), 0);
        chk("t1_done_cnt", done_cnt - done_base, 1);

        // Heat on wash pass only, two rinse passes.
        heat_base = heat_cnt; drain_base = drain_entries; done_base = done_cnt;
        bus.n_rinses = 2'd2;
        bus.start = 1'b1; cyc(); bus.start = 1'b0;
        chk("t2_fill", int'(bus.state_o), 1);
        bus.full = 1'b1; bus.cold = 1'b1; bus.empty = 1'b1;
        cyc();
        chk("t2_heat", int'(bus.state_o), 2);
        repeat (4) cyc();
        bus.cold = 1'b0; cyc();
        chk("t2_agit1", int'(bus.state_o), 3);
        bus.cold = 1'b1;
        measure(3'd3, n);
        chk("t2_wash_len", n, 40);
        cyc();
        chk("t2_fill_r1", int'(bus.state_o), 1);
        cyc();
        chk("t2_agit_r1", int'(bus.state_o), 3);
        measure(3'd3, n);
        chk("t2_rinse1_len", n, 20);
        cyc(); cyc();
        chk("t2_agit_r2", int'(bus.state_o), 3);
        measure(3'd3, n);
        chk("t2_rinse2_len", n, 20);
        cyc();
        chk("t2_spin", int'(bus.state_o), 5);
        measure(3'd5, n);
        chk("t2_spin_len", n, 20);
        cyc();
        chk("t2_idle", int'(bus.state_o), 0);
        chk("t2_heat_cnt", heat_cnt - heat_base, 5);
        chk("t2_drain_entries", drain_entries - drain_base, 3);
        chk("t2_done_cnt", done_cnt - done_base, 1);

        // full/empty held high, one rinse; stray start and n_rinses change mid-program.
        bus.cold = 1'b0; bus.n_rinses = 2'd1;
        bus.start = 1'b1; cyc(); bus.start = 1'b0;
        chk("t5_fill", int'(bus.state_o), 1);
        cyc();
        chk("t5_agit", int'(bus.state_o), 3);
        bus.start = 1'b1; bus.n_rinses = 2'd3; cyc(); bus.start = 1'b0;
        measure(3'd3, n);
        chk("t5_wash_rest", n, 39);
        chk("t5_drain", int'(bus.state_o), 4);
        cyc();
        chk("t5_fill_r", int'(bus.state_o), 1);
        cyc();
        measure(3'd3, n);
        chk("t5_rinse_len", n, 20);
        cyc();
        chk("t5_spin_one_rinse", int'(bus.state_o), 5);
        measure(3'd5, n);
        chk("t5_spin_len", n, 20);
        cyc();
        chk("t5_idle", int'(bus.state_o), 0);

        // Abort mid-wash at timer 10.
        done_base = done_cnt;
        bus.n_rinses = 2'd0; bus.empty = 1'b0;
        bus.start = 1'b1; cyc(); bus.start = 1'b0;
        cyc();
        k = 0;
        while (bus.timer_o != 8'd10 && k < 100) begin k++; cyc(); end
        chk("t3_timer10", int'(bus.timer_o), 10);
        bus.abort = 1'b1; cyc(); bus.abort = 1'b0;
        chk("t3_drain", int'(bus.state_o), 4);
        chk("t3_timer_clr", int'(bus.timer_o), 0);
        cyc();
        chk("t3_drain_hold", int'(bus.state_o), 4);
        bus.empty = 1'b1; cyc();
        chk("t3_idle", int'(bus.state_o), 0);
        chk("t3_ready", int'(bus.ready), 1);
        chk("t3_no_done", done_cnt - done_base, 0);

        // Start beats abort in IDLE; abort in FILL beats full.
        bus.abort = 1'b1; bus.start = 1'b1; cyc(); bus.start = 1'b0;
        chk("t6_start_wins", int'(bus.state_o), 1);
        cyc(); bus.abort = 1'b0;
        chk("t6_fill_abort", int'(bus.state_o), 4);
        cyc();
        chk("t6_idle", int'(bus.state_o), 0);

        // Reset during SPIN; start ignored while reset high.
        bus.start = 1'b1; cyc(); bus.start = 1'b0;
        cyc();
        measure(3'd3, n);
        cyc();
        chk("t4_spin", int'(bus.state_o), 5);
        repeat (4) cyc();
        chk("t4_spin_timer", int'(bus.timer_o), 15);
        reset = 1'b1; bus.start = 1'b1; cyc();
        chk("t4_rst_state", int'(bus.state_o), 0);
        chk("t4_rst_ready", int'(bus.ready), 1);
        chk("t4_rst_speed", int'(bus.speed), 0);
        chk("t4_rst_timer", int'(bus.timer_o), 0);
        cyc();
        chk("t4_rst_start_ign", int'(bus.state_o), 0);
        reset = 1'b0; bus.start = 1'b0; cyc();
        chk("t4_idle_after", int'(bus.state_o), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/washing_machine_ctrl.md
Name: washing_machine_ctrl

Overview:
Parametrised washing-machine sequencer: fill, optional heat, timed wash, drain, programmable number of rinse passes, timed spin, completion pulse. Built-in cycle timer replaces fixed durations; adds abort and rinse repetition. Sits between panel inputs (start/abort/rinse count) and sensor/actuator pins (full, cold, empty; valve, heater, motor, pump).

Parameters:
CNT_W, 8, width of phase timer and timer_o
WASH_CYCLES, 40, wash phase length in clk cycles (1..2^CNT_W-1)
RINSE_CYCLES, 20, rinse agitation length in clk cycles (1..2^CNT_W-1)
SPIN_CYCLES, 20, spin phase length in clk cycles (1..2^CNT_W-1)
R_W, 2, width of n_rinses (max rinse passes 2^R_W-1)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
start  in  1  begin program (honoured only in IDLE)
abort  in  1  cancel program, drain and return to IDLE
n_rinses  in  R_W  rinse passes, latched on accepted start
full  in  1  drum-full sensor
cold  in  1  water below temperature
empty  in  1  drum-empty sensor
ready  out  1  idle, accepts start
water_in  out  1  inlet valve
heat_r  out  1  heater
wash  out  1  drum agitation (wash and rinse)
drain  out  1  drain pump
speed  out  1  spin motor
done  out  1  one-cycle completion pulse
state_o  out  3  current state code
timer_o  out  CNT_W  cycles remaining in timed phase, 0 otherwise

Behaviour:
- Reset (synchronous, active-high, sampled on posedge clk) overrides all: state IDLE, timer 0, rinse counter 0, latched n_rinses 0, rinse flag 0, abort flag 0. Outputs after reset: ready=1, all others 0, state_o=0, timer_o=0.
- States/codes: IDLE 0, FILL 1, HEAT 2, AGITATE 3, DRAIN 4, SPIN 5, DONE 6. Code 7 illegal -> IDLE next cycle.
- All outputs are Moore decode of registered state/timer; no input-to-output combinational path. One output set per state: IDLE ready; FILL water_in; HEAT heat_r; AGITATE wash; DRAIN drain; SPIN speed; DONE done. timer_o equals timer register in AGITATE/SPIN, else 0.
- IDLE: start=1 -> FILL, latch n_rinses, rinse flag=0, rinse count=0.
- FILL: stays until full=1. Then: pass not a rinse and cold=1 -> HEAT; otherwise -> AGITATE. Full already 1 on entry -> FILL lasts exactly one cycle.
- HEAT: stays while cold=1; cold=0 -> AGITATE. Never entered on rinse passes.
- AGITATE: timer loaded with length-1 on entry (WASH_CYCLES on wash pass, RINSE_CYCLES on rinse pass), decrements each cycle; when timer==0 -> DRAIN. Phase lasts exactly its length in cycles.
- DRAIN: stays until empty=1. Then: abort flag set -> IDLE (no done pulse, flag cleared); rinse count < latched n_rinses -> FILL with rinse flag=1, rinse count+1; else -> SPIN.
- SPIN: timer loaded with SPIN_CYCLES-1, lasts exactly SPIN_CYCLES cycles -> DONE.
- DONE: one cycle, done=1 -> IDLE.
- abort=1 in FILL, HEAT, AGITATE or SPIN -> DRAIN next cycle, abort flag set, timer cleared. abort in DRAIN sets flag, stays DRAIN. abort in IDLE/DONE ignored.
- Simultaneous events: abort beats full/cold/timer expiry; start outside IDLE ignored; abort and start together in IDLE -> start wins (abort ignored in IDLE).
- n_rinses=0 -> no rinse pass: DRAIN goes straight to SPIN.
- Timer never wraps: holds at 0 outside timed phases; length parameters of 0 are illegal (elaboration check).

Decomposition:
- Shared package washing_machine_pkg: state enum/localparams (codes above), state width constant.
- One sub-module: phase_timer (CNT_W-bit down counter; load, value, clear inputs; expired flag when zero).

Test Plan:
- Basic program, n_rinses=0, cold=0, full 3 cycles after FILL entry, empty 2 cycles after DRAIN entry -> state sequence 0,1,3,4,5,6,0; wash high exactly 40 cycles, speed exactly 20, done one cycle.
- cold=1 at full, released after 5 cycles, n_rinses=2 -> heat_r 5 cycles on first pass only; AGITATE lengths 40,20,20; three DRAIN entries; then SPIN 20, done.
- abort during AGITATE at timer_o=10 -> next cycle DRAIN, timer_o=0; on empty -> IDLE, ready=1, done never asserted.
- Reset asserted mid-SPIN for one cycle -> next cycle state_o=0, ready=1, speed=0, timer_o=0; start ignored while reset high.
- full=1 and empty=1 held constant, cold=0, n_rinses=1 -> FILL and DRAIN each exactly one cycle; sequence 1,3(40),4,1,3(20),4,5(20),6.
- start pulsed during AGITATE, and n_rinses changed mid-program from 1 to 3 -> no effect; exactly one rinse pass executed.
